// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm -- multi-cycle MIPS-subset control unit.
// Decodes opcode/funct into a Moore-style sequence of datapath controls. The
// branch PC write additionally follows the ALU zero flag in the same cycle.
// Optional feature: define MCPU_JAL_EN to enable the JAL and JR instructions.
// Without it those encodings trap to ILLEGAL and the JAL/JR states do not exist.
// HALT_ON_ILLEGAL = 1 parks the FSM in ILLEGAL until reset. HALT_ON_ILLEGAL = 0
// spends one ILLEGAL cycle and then refetches.
// reset is asynchronous and active-low.
module mcpu_ctrl_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       a_we,
  output logic       b_we,
  output logic       ben,
  output logic       mem_in,
  output logic       beq_bne,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_in,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
`ifdef MCPU_JAL_EN
    JAL      = 4'd12,
    JR       = 4'd13,
`endif
    ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
`ifdef MCPU_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
`endif

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  state_t state_q, state_d;

  // Enables before reset gating. FETCH drives them, so they must be masked
  // while reset is held low.
  logic pc_we_c, ir_we_c, mem_we_c, reg_we_c, a_we_c, b_we_c, ben_c;

  // State register: reset forces FETCH immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed successors, with the opcode/funct dispatch in DECODE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) state_d = EXEC_R;
`ifdef MCPU_JAL_EN
            else if (funct == FN_JR) state_d = JR;
`endif
            else state_d = ILLEGAL;
          end
          OP_ADDI, OP_XORI: state_d = EXEC_I;
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
`ifdef MCPU_JAL_EN
          OP_JAL:           state_d = JAL;
`endif
          default:          state_d = ILLEGAL;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = MEM_WB;
      ILLEGAL:  state_d = HALT_ON_ILLEGAL ? ILLEGAL : FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Output decode: every control signal is 0 unless the current state drives it.
  always_comb begin
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    a_we_c    = 1'b0;
    b_we_c    = 1'b0;
    ben_c     = 1'b0;
    mem_in    = 1'b0;
    beq_bne   = 1'b0;
    reg_dst   = 2'd0;
    reg_in    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = ALU_ADD;
    pc_src    = 2'd0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        alu_src_b = 2'd3;
        pc_src    = 2'd2;
      end
      DECODE: begin
        a_we_c = 1'b1;
        b_we_c = 1'b1;
        ben_c  = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        if (funct == FN_SUB)      alu_op = ALU_SUB;
        else if (funct == FN_SLT) alu_op = ALU_SLT;
        else                      alu_op = ALU_ADD;
      end
      WB_R: reg_we_c = 1'b1;
      EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      WB_I: begin
        reg_we_c = 1'b1;
        reg_dst  = 2'd1;
      end
      MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      MEM_RD: mem_in = 1'b1;
      MEM_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = 2'd1;
        reg_in   = 2'd1;
      end
      MEM_WR: begin
        mem_we_c = 1'b1;
        mem_in   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = ALU_SUB;
        pc_src    = 2'd3;
        beq_bne   = opcode[0];
        pc_we_c   = zero ^ opcode[0];
      end
      JUMP: begin
        pc_we_c = 1'b1;
        pc_src  = 2'd1;
      end
`ifdef MCPU_JAL_EN
      JAL: begin
        pc_we_c  = 1'b1;
        reg_we_c = 1'b1;
        pc_src   = 2'd1;
        reg_dst  = 2'd2;
        reg_in   = 2'd2;
      end
      JR: begin
        pc_we_c   = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_src    = 2'd2;
      end
`endif
      ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign pc_we  = reset & pc_we_c;
  assign ir_we  = reset & ir_we_c;
  assign mem_we = reset & mem_we_c;
  assign reg_we = reset & reg_we_c;
  assign a_we   = reset & a_we_c;
  assign b_we   = reset & b_we_c;
  assign ben    = reset & ben_c;
  assign state  = state_q;

endmodule
